// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: single-outstanding load/store engine between decoder controls and a req/ack data bus
module data_mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic              load_byte,
  input  logic              store_byte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              done,
  output logic              access_err,
  output logic [DATA_W-1:0] load_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic req, byte_in, aligned, launch, byte_q;
  logic [1:0] lane_q;
  logic [7:0] rbyte;
  logic [DATA_W-1:0] load_d;
  assign req     = read_mem | write_mem;
  assign byte_in = write_mem ? store_byte : load_byte;
  assign aligned = byte_in | (addr[1:0] == 2'b00);
  assign launch  = (state_q == IDLE) & req & aligned;
  assign rbyte   = bus_rdata[8*lane_q +: 8];
  assign load_d  = byte_q ? {{(DATA_W-8){rbyte[7]}}, rbyte} : bus_rdata;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) state_d = aligned ? BUSY : ERR;
      end
      BUSY:
        if (bus_ack) state_d = DONE;
        else if (cnt_q == 16'(TIMEOUT - 1)) state_d = ERR;
        else cnt_d = cnt_q + 16'd1;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    stall      = ((state_q == IDLE) & req) | (state_q == BUSY);
    bus_req    = state_q == BUSY;
    done       = (state_q == DONE) | (state_q == ERR);
    access_err = state_q == ERR;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus_we    <= 1'b0;
      byte_q    <= 1'b0;
      lane_q    <= '0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      load_data <= '0;
    end else begin
      if (launch) begin
        bus_we    <= write_mem;
        byte_q    <= byte_in;
        lane_q    <= addr[1:0];
        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
        bus_sel   <= byte_in ? 4'b0001 << addr[1:0] : 4'b1111;
        bus_wdata <= byte_in ? {4{store_data[7:0]}} : store_data;
      end
      if ((state_q == BUSY) & bus_ack & ~bus_we) load_data <= load_d;
    end
endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit: directed checks of loads, stores, alignment errors, timeout and reset
module tb_data_mem_access_unit;
  logic clk = 0, rst = 1;
  logic read_mem = 0, write_mem = 0, load_byte = 0, store_byte = 0, bus_ack = 0;
  logic [31:0] addr = 0, store_data = 0, bus_rdata = 0;
  logic stall, done, access_err, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0] bus_sel;
  int passed = 0, total = 0;
  int n_stall, n_req;
  logic got_done, got_err, c_we;
  logic [3:0] c_sel;
  logic [31:0] c_addr, c_wdata;

  data_mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .read_mem(read_mem), .write_mem(write_mem),
    .load_byte(load_byte), .store_byte(store_byte), .addr(addr), .store_data(store_data),
    .stall(stall), .done(done), .access_err(access_err), .load_data(load_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one access, acking on the ack_at-th bus_req cycle (0 = never), and records what the bus saw.
  task automatic access(input logic w, both, b, input logic [31:0] a, d, rd, input int ack_at);
    read_mem = !w | both; write_mem = w; load_byte = b; store_byte = b;
    addr = a; store_data = d; bus_rdata = rd;
    n_stall = 0; n_req = 0; got_done = 0; got_err = 0;
    c_sel = 'x; c_addr = 'x; c_wdata = 'x; c_we = 'x;
    #1;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (stall) n_stall++;
      if (bus_req) begin
        n_req++;
        if (n_req == 1) begin c_sel = bus_sel; c_addr = bus_addr; c_wdata = bus_wdata; c_we = bus_we; end
      end
      bus_ack = bus_req && n_req == ack_at;
      if (done) begin got_done = 1; got_err = access_err; read_mem = 0; write_mem = 0; end
      tick();
      bus_ack = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0; #1;
    total++; if ({stall, done, access_err, bus_req, bus_we} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {stall, done, access_err, bus_req, bus_we}); else passed++;
    total++; if (bus_sel !== 4'h0) $display("FAIL reset_sel: got %h want 0", bus_sel); else passed++;
    total++; if ({bus_addr, bus_wdata, load_data} !== 96'h0) $display("FAIL reset_data: got %h %h %h want 0", bus_addr, bus_wdata, load_data); else passed++;
    tick();
  endtask

  task automatic test_word_store();
    access(1, 0, 0, 32'h100, 32'hDEADBEEF, 0, 3);
    total++; if (c_sel !== 4'hF) $display("FAIL wst_sel: got %h want f", c_sel); else passed++;
    total++; if (c_addr !== 32'h100) $display("FAIL wst_addr: got %h want 100", c_addr); else passed++;
    total++; if (c_wdata !== 32'hDEADBEEF) $display("FAIL wst_wdata: got %h want deadbeef", c_wdata); else passed++;
    total++; if (c_we !== 1'b1) $display("FAIL wst_we: got %b want 1", c_we); else passed++;
    total++; if (n_stall != 4) $display("FAIL wst_stall: got %0d want 4", n_stall); else passed++;
    total++; if (n_req != 3) $display("FAIL wst_req: got %0d want 3", n_req); else passed++;
    total++; if ({got_done, got_err} !== 2'b10) $display("FAIL wst_done: got %b want 10", {got_done, got_err}); else passed++;
    total++; if ({done, stall, bus_req} !== 3'b0) $display("FAIL wst_idle: got %b want 000", {done, stall, bus_req}); else passed++;
  endtask

  task automatic test_byte_loads();
    access(0, 0, 1, 32'h203, 0, 32'h80FF7F01, 1);
    total++; if (c_sel !== 4'h8) $display("FAIL lb3_sel: got %h want 8", c_sel); else passed++;
    total++; if (c_addr !== 32'h200) $display("FAIL lb3_addr: got %h want 200", c_addr); else passed++;
    total++; if (c_we !== 1'b0) $display("FAIL lb3_we: got %b want 0", c_we); else passed++;
    total++; if (load_data !== 32'hFFFFFF80) $display("FAIL lb3_data: got %h want ffffff80", load_data); else passed++;
    total++; if (n_stall != 2) $display("FAIL lb3_stall: got %0d want 2", n_stall); else passed++;
    access(0, 0, 1, 32'h201, 0, 32'h80FF7F01, 2);
    total++; if (c_sel !== 4'h2) $display("FAIL lb1_sel: got %h want 2", c_sel); else passed++;
    total++; if (load_data !== 32'h0000007F) $display("FAIL lb1_data: got %h want 0000007f", load_data); else passed++;
    access(0, 0, 1, 32'h202, 0, 32'h80FF7F01, 1);
    total++; if (load_data !== 32'hFFFFFFFF) $display("FAIL lb2_data: got %h want ffffffff", load_data); else passed++;
  endtask

  task automatic test_word_load();
    access(0, 0, 0, 32'h300, 0, 32'h12345678, 2);
    total++; if (c_sel !== 4'hF) $display("FAIL lw_sel: got %h want f", c_sel); else passed++;
    total++; if (load_data !== 32'h12345678) $display("FAIL lw_data: got %h want 12345678", load_data); else passed++;
  endtask

  task automatic test_byte_store();
    access(1, 0, 1, 32'h2, 32'h123456AB, 0, 1);
    total++; if (c_sel !== 4'h4) $display("FAIL sb_sel: got %h want 4", c_sel); else passed++;
    total++; if (c_wdata !== 32'hABABABAB) $display("FAIL sb_wdata: got %h want abababab", c_wdata); else passed++;
    total++; if (c_we !== 1'b1) $display("FAIL sb_we: got %b want 1", c_we); else passed++;
    total++; if (c_addr !== 32'h0) $display("FAIL sb_addr: got %h want 0", c_addr); else passed++;
    total++; if (load_data !== 32'h12345678) $display("FAIL sb_load_kept: got %h want 12345678", load_data); else passed++;
  endtask

  task automatic test_write_priority();
    access(1, 1, 0, 32'h40, 32'hCAFEF00D, 32'h55555555, 1);
    total++; if (c_we !== 1'b1) $display("FAIL prio_we: got %b want 1", c_we); else passed++;
    total++; if (load_data !== 32'h12345678) $display("FAIL prio_load_kept: got %h want 12345678", load_data); else passed++;
  endtask

  task automatic test_misaligned();
    access(0, 0, 0, 32'h6, 0, 32'hAAAAAAAA, 1);
    total++; if (n_req != 0) $display("FAIL mis_req: got %0d want 0", n_req); else passed++;
    total++; if (n_stall != 1) $display("FAIL mis_stall: got %0d want 1", n_stall); else passed++;
    total++; if ({got_done, got_err} !== 2'b11) $display("FAIL mis_err: got %b want 11", {got_done, got_err}); else passed++;
    total++; if (load_data !== 32'h12345678) $display("FAIL mis_load_kept: got %h want 12345678", load_data); else passed++;
    access(1, 0, 0, 32'h11, 32'h1, 0, 1);
    total++; if ({n_req, 30'b0, got_err} !== {32'd0, 31'b1}) $display("FAIL mis_store: req %0d err %b want 0 1", n_req, got_err); else passed++;
  endtask

  task automatic test_timeout();
    access(0, 0, 0, 32'h10, 0, 32'hBBBBBBBB, 0);
    total++; if (n_req != 4) $display("FAIL to_req: got %0d want 4", n_req); else passed++;
    total++; if ({got_done, got_err} !== 2'b11) $display("FAIL to_err: got %b want 11", {got_done, got_err}); else passed++;
    total++; if (load_data !== 32'h12345678) $display("FAIL to_load_kept: got %h want 12345678", load_data); else passed++;
    access(0, 0, 1, 32'h20, 0, 32'h80FF7F01, 1);
    total++; if ({got_done, got_err} !== 2'b10) $display("FAIL to_next_done: got %b want 10", {got_done, got_err}); else passed++;
    total++; if (load_data !== 32'h00000001) $display("FAIL to_next_data: got %h want 00000001", load_data); else passed++;
  endtask

  task automatic test_reset_mid_busy();
    read_mem = 1; load_byte = 0; addr = 32'h400; bus_rdata = 32'h77777777;
    tick();
    tick();
    total++; if (bus_req !== 1'b1) $display("FAIL rmb_busy: got %b want 1", bus_req); else passed++;
    rst = 1; read_mem = 0;
    tick();
    rst = 0;
    total++; if ({stall, done, access_err, bus_req, bus_we, bus_sel} !== 9'b0) $display("FAIL rmb_ctrl: got %b want 0", {stall, done, access_err, bus_req, bus_we, bus_sel}); else passed++;
    total++; if ({bus_addr, bus_wdata, load_data} !== 96'h0) $display("FAIL rmb_data: got %h %h %h want 0", bus_addr, bus_wdata, load_data); else passed++;
    bus_ack = 1;
    tick();
    bus_ack = 0;
    total++; if ({done, access_err, stall} !== 3'b0) $display("FAIL rmb_late_ack: got %b want 000", {done, access_err, stall}); else passed++;
    tick();
    total++; if ({done, load_data} !== 33'h0) $display("FAIL rmb_after: got %b %h want 0", done, load_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_loads();
    test_word_load();
    test_byte_store();
    test_write_priority();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
Executes the memory operations that the instruction decoder requests. It consumes the decoder's read_mem, write_mem, load_byte and store_byte controls plus the ALU address and store data. It drives a single-outstanding request/acknowledge data bus and holds the pipeline stalled until the access completes. It returns load data (byte loads sign-extended) for the mem_to_reg writeback path.

Parameters:
ADDR_W, 32, width of the address and bus_addr.
DATA_W, 32, data width; fixed at 32 because byte lanes assume 4 bytes.
TIMEOUT, 255, maximum cycles to wait for bus_ack before aborting (1..65535).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
read_mem  input  1  decoder: load requested.
write_mem  input  1  decoder: store requested.
load_byte  input  1  decoder: load is a byte (LB), else word.
store_byte  input  1  decoder: store is a byte (SB), else word.
addr  input  ADDR_W  effective address from the ALU.
store_data  input  DATA_W  rs2 value.
stall  output  1  holds the pipeline; combinational.
done  output  1  one-cycle pulse: access finished (good or error).
access_err  output  1  one-cycle pulse with done: misaligned access or timeout.
load_data  output  DATA_W  registered load result, valid from done until the next load completes.
bus_req  output  1  request valid.
bus_we  output  1  1 = write.
bus_addr  output  ADDR_W  word-aligned address (bits [1:0] = 0).
bus_sel  output  4  byte-lane enables.
bus_wdata  output  DATA_W  write data, lane-replicated.
bus_ack  input  1  responder completes the request in this cycle.
bus_rdata  input  DATA_W  read data, valid when bus_ack = 1.

Behaviour:
- Reset (sync, rst = 1 at clk edge): state IDLE; bus_req, bus_we, bus_sel, bus_addr, bus_wdata, load_data, done, access_err, timeout counter all 0. Reset mid-transaction drops bus_req on the next edge without waiting for ack. A late ack in IDLE is ignored.
- Request: req = read_mem | write_mem. If both are high, the write wins and the read is ignored.
- Alignment: byte access is always aligned. Word access requires addr[1:0] = 0.
- stall = (state == IDLE & req) | (state == BUSY). stall is 0 in DONE and ERR.
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE, req and aligned: at the edge, latch we, size, lane = addr[1:0] and bus fields; go to BUSY. bus_req = 1 from the first BUSY cycle (1-cycle launch latency).
- IDLE, req and misaligned word: go to ERR. No bus activity.
- BUSY: bus_req, bus_we, bus_addr, bus_sel and bus_wdata stay stable until ack. On bus_ack = 1: bus_req = 0 next cycle, capture load data if read, go to DONE. Ack in the first BUSY cycle is legal (minimum access is 2 cycles of stall).
- BUSY timeout: counter increments each BUSY cycle without ack. When it reaches TIMEOUT-1 without ack: drop bus_req, go to ERR, load_data unchanged.
- DONE: done = 1 for one cycle, then go to IDLE. The pipeline advances at the end of this cycle.
- ERR: done = 1 and access_err = 1 for one cycle, then go to IDLE.
- No new request is accepted in DONE or ERR, so the same instruction is never re-launched.
- Byte store: bus_sel = 1 << addr[1:0]; bus_wdata = {4{store_data[7:0]}}.
- Word store: bus_sel = 4'b1111; bus_wdata = store_data.
- Byte load: bus_sel = 1 << lane; load_data = sign-extend of bus_rdata[8*lane+7 : 8*lane].
- Word load: bus_sel = 4'b1111; load_data = bus_rdata.
- bus_addr = {addr[ADDR_W-1:2], 2'b00}.
- With req = 0 in IDLE: no state change, stall = 0.

Test Plan:
- Word store: addr = 0x100, store_data = 0xDEADBEEF, write_mem = 1, ack 3 cycles after bus_req rises -> bus_sel = 1111, bus_addr = 0x100, bus_wdata = 0xDEADBEEF; stall high 4 cycles; done pulse on the cycle after ack.
- Byte loads: bus_rdata = 0x80FF7F01. Byte load at addr 0x203 (lane 3) -> bus_sel = 1000, load_data = 0xFFFFFF80. Byte load at lane 1 -> load_data = 0x0000007F.
- Byte store: addr = 0x2, store_data = 0x123456AB -> bus_sel = 0100, bus_wdata = 0xABABABAB, bus_we = 1.
- Misaligned word load at addr 0x6 -> bus_req never rises; stall for 1 cycle; done = access_err = 1 the next cycle; load_data unchanged.
- Timeout: TIMEOUT = 4, no ack -> bus_req high 4 cycles then low; access_err pulse; FSM returns to IDLE and accepts the next request.
- Reset mid-BUSY: rst at cycle 2 of BUSY -> all outputs 0 the next cycle; ack arriving afterwards produces no done.
